// File: rtl/ldl_pwm_deadtime_if.sv
// Configuration bus of the LDL PWM generator: one period/duty pair offered
// with a valid/ready handshake into the shadow register.
interface ldl_pwm_deadtime_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_max;
    logic [WIDTH-1:0] cfg_duty;

    // Side that offers new settings
    modport master (
        output cfg_valid,
        output cfg_max,
        output cfg_duty,
        input  cfg_ready
    );

    // PWM generator side
    modport slave (
        input  cfg_valid,
        input  cfg_max,
        input  cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/ldl_pwm_deadtime.sv
// PWM generator for the LDL up-counter. Closes the counter loop through
// cnt_max, double-buffers period/duty so updates land only at period wrap,
// and drives a complementary high/low pair separated by a programmable dead
// time in which both sides are low.
module ldl_pwm_deadtime #(
    parameter int WIDTH   = 8,
    parameter int DEAD    = 0,
    parameter int RST_MAX = 2**WIDTH-1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 cnt_en,
    input  logic [WIDTH-1:0]     cnt,
    output logic [WIDTH-1:0]     cnt_max,
    ldl_pwm_deadtime_if.slave    cfg,
    output logic                 wrap,
    output logic                 out_h,
    output logic                 out_l
);

    // dt must hold DEAD-1; keep at least one bit so DEAD=0 still elaborates
    localparam int DTW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [DTW-1:0]   DT_LOAD = (DEAD > 0) ? DTW'(DEAD - 1) : '0;
    localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(RST_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        DT_H,
        HIGH,
        DT_L
    } state_t;

    logic [WIDTH-1:0] act_max;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] shd_max;
    logic [WIDTH-1:0] shd_duty;
    logic             pending;
    logic             raw_q;
    logic             wrap_ev;
    logic             accept;
    logic [DTW-1:0]   dt;
    logic [DTW-1:0]   dt_n;
    state_t           state;
    state_t           state_n;

    // The counter restarts from 0 in the cycle it reaches the active period
    assign wrap_ev = cnt_en && (cnt >= act_max);
    assign accept  = cfg.cfg_valid && !pending;

    assign cfg.cfg_ready = !pending;
    assign cnt_max       = act_max;
    assign out_h         = (state == HIGH);
    assign out_l         = (state == LOW);

    // Shadow capture of offered settings; no reset needed, pending guards use
    always_ff @(posedge clk) begin
        if (accept) begin
            shd_max  <= cfg.cfg_max;
            shd_duty <= cfg.cfg_duty;
        end
    end

    // Active registers, pending flag and wrap pulse; shadow moves to active only at wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_max  <= MAX_RST;
            act_duty <= '0;
            pending  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= wrap_ev;
            // ready is low while pending, so accept and apply never coincide
            if (wrap_ev && pending) begin
                act_max  <= shd_max;
                act_duty <= shd_duty;
                pending  <= 1'b0;
            end else if (accept) begin
                pending <= 1'b1;
            end
        end
    end

    // ---- stage p1: raw PWM compare, independent of cnt_en ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= (cnt < act_duty);
        end
    end

    // ---- stage p2: output state and dead-time counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            dt    <= '0;
        end else begin
            state <= state_n;
            dt    <= dt_n;
        end
    end

    // Next-state logic; run=0 wins over everything so both sides drop at once
    always_comb begin
        state_n = state;
        dt_n    = dt;
        if (!run) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (raw_q) begin
                        state_n = (DEAD == 0) ? HIGH : DT_H;
                    end else begin
                        state_n = (DEAD == 0) ? LOW : DT_L;
                    end
                    dt_n = DT_LOAD;
                end
                LOW: begin
                    if (raw_q) begin
                        state_n = (DEAD == 0) ? HIGH : DT_H;
                        dt_n    = DT_LOAD;
                    end
                end
                DT_H: begin
                    if (!raw_q) begin
                        state_n = LOW;
                    end else if (dt == '0) begin
                        state_n = HIGH;
                    end else begin
                        dt_n = dt - DTW'(1);
                    end
                end
                HIGH: begin
                    if (!raw_q) begin
                        state_n = (DEAD == 0) ? LOW : DT_L;
                        dt_n    = DT_LOAD;
                    end
                end
                DT_L: begin
                    if (raw_q) begin
                        state_n = HIGH;
                    end else if (dt == '0) begin
                        state_n = LOW;
                    end else begin
                        dt_n = dt - DTW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldl_pwm_deadtime.sv
// Bench for ldl_pwm_deadtime: two instances (no dead time and DEAD=2), each
// closed through its own up-counter model, driven with directed scenarios.
module tb_ldl_pwm_deadtime;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       cnt_en;
    logic       cfg_valid;
    logic [3:0] cfg_max;
    logic [3:0] duty0;
    logic [3:0] duty2;

    logic [3:0] cnt0, cnt2;
    logic [3:0] cnt_max0, cnt_max2;
    logic       wrap0, wrap2;
    logic       out_h0, out_l0, out_h2, out_l2;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    // expected per-cycle outputs, index 0 = cycle showing the wrap pulse
    logic h0_tab [0:9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    logic l0_tab [0:9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic h2_tab [0:9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic l2_tab [0:9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    ldl_pwm_deadtime_if #(.WIDTH(4)) if0 ();
    ldl_pwm_deadtime_if #(.WIDTH(4)) if2 ();

    assign if0.cfg_valid = cfg_valid;
    assign if0.cfg_max   = cfg_max;
    assign if0.cfg_duty  = duty0;
    assign if2.cfg_valid = cfg_valid;
    assign if2.cfg_max   = cfg_max;
    assign if2.cfg_duty  = duty2;

    ldl_pwm_deadtime #(.WIDTH(4), .DEAD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .cnt_en(cnt_en), .cnt(cnt0),
        .cnt_max(cnt_max0), .cfg(if0), .wrap(wrap0), .out_h(out_h0), .out_l(out_l0)
    );

    ldl_pwm_deadtime #(.WIDTH(4), .DEAD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .cnt_en(cnt_en), .cnt(cnt2),
        .cnt_max(cnt_max2), .cfg(if2), .wrap(wrap2), .out_h(out_h2), .out_l(out_l2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // upstream counters, 0..cnt_max
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt2 <= '0;
        end else if (cnt_en) begin
            cnt0 <= (cnt0 >= cnt_max0) ? 4'd0 : cnt0 + 4'd1;
            cnt2 <= (cnt2 >= cnt_max2) ? 4'd0 : cnt2 + 4'd1;
        end
    end

    always @(negedge clk) begin
        if ((out_h0 === 1'b1 && out_l0 === 1'b1) || (out_h2 === 1'b1 && out_l2 === 1'b1))
            overlap = overlap + 1;
    end

    task automatic cfg_write(input logic [3:0] m, input logic [3:0] d0, input logic [3:0] d2);
        int n = 0;
        while (if0.cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if0.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write_timeout: cfg_ready=%b required 1", if0.cfg_ready);
        end
        cfg_max   = m;
        duty0     = d0;
        duty2     = d2;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_wrap(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wrap0 !== 1'b1 && n < bound);
        checks++;
        if (wrap0 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_timeout: wrap=%b required 1 within %0d cycles", wrap0, bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; cnt_en = 1'b0; cfg_valid = 1'b0;
        cfg_max = '0; duty0 = '0; duty2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_h0 !== 1'b0 || out_l0 !== 1'b0 || out_h2 !== 1'b0 || out_l2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: h0=%b l0=%b h2=%b l2=%b required all 0", out_h0, out_l0, out_h2, out_l2);
        end
        checks++;
        if (wrap0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b required 0", wrap0);
        end
        checks++;
        if (if0.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", if0.cfg_ready);
        end
        checks++;
        if (cnt_max0 !== 4'd15 || cnt_max2 !== 4'd15) begin
            errors++;
            $display("FAIL reset_cnt_max: got %0d/%0d required 15", cnt_max0, cnt_max2);
        end
    endtask

    task automatic test_basic_period();
        rst_n = 1'b1; run = 1'b1; cnt_en = 1'b1;
        cfg_write(4'd9, 4'd3, 4'd5);
        wait_wrap(40);
        checks++;
        if (cnt_max0 !== 4'd9 || cnt_max2 !== 4'd9) begin
            errors++;
            $display("FAIL apply_max: got %0d/%0d required 9", cnt_max0, cnt_max2);
        end
        wait_wrap(20);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (out_h0 !== h0_tab[j] || out_l0 !== l0_tab[j]) begin
                errors++;
                $display("FAIL period_dead0 j=%0d: h=%b l=%b required h=%b l=%b", j, out_h0, out_l0, h0_tab[j], l0_tab[j]);
            end
            checks++;
            if (out_h2 !== h2_tab[j] || out_l2 !== l2_tab[j]) begin
                errors++;
                $display("FAIL period_dead2 j=%0d: h=%b l=%b required h=%b l=%b", j, out_h2, out_l2, h2_tab[j], l2_tab[j]);
            end
            checks++;
            if (wrap0 !== (j == 0)) begin
                errors++;
                $display("FAIL wrap_pulse j=%0d: got %b required %b", j, wrap0, (j == 0));
            end
        end
        @(negedge clk);
        checks++;
        if (wrap0 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_period10: got %b required 1", wrap0);
        end
    endtask

    task automatic test_shadow_update();
        int n;
        repeat (3) @(negedge clk);
        cfg_write(4'd4, 4'd2, 4'd2);
        checks++;
        if (if0.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL pending_ready: got %b required 0", if0.cfg_ready);
        end
        // second offer held while the shadow is full
        cfg_max = 4'd6; duty0 = 4'd1; duty2 = 4'd1; cfg_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (wrap0 !== 1'b1) begin
                checks++;
                if (if0.cfg_ready !== 1'b0 || cnt_max0 !== 4'd9) begin
                    errors++;
                    $display("FAIL stall: ready=%b cnt_max=%0d required 0 and 9", if0.cfg_ready, cnt_max0);
                end
            end
        end while (wrap0 !== 1'b1 && n < 30);
        checks++;
        if (wrap0 !== 1'b1 || cnt_max0 !== 4'd4 || if0.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL shadow_apply: wrap=%b cnt_max=%0d ready=%b required 1, 4, 1", wrap0, cnt_max0, if0.cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (if0.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_accept: ready=%b required 0", if0.cfg_ready);
        end
        n = 1;
        do begin
            @(negedge clk);
            n++;
        end while (wrap0 !== 1'b1 && n < 20);
        checks++;
        if (n !== 5 || wrap0 !== 1'b1) begin
            errors++;
            $display("FAIL period5: wrap after %0d cycles required 5", n);
        end
        checks++;
        if (cnt_max0 !== 4'd6 || cnt_max2 !== 4'd6) begin
            errors++;
            $display("FAIL second_apply: cnt_max=%0d/%0d required 6", cnt_max0, cnt_max2);
        end
    endtask

    task automatic test_duty_limits();
        cfg_write(4'd9, 4'd0, 4'd0);
        wait_wrap(20);
        wait_wrap(20);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (out_h0 !== 1'b0 || out_l0 !== 1'b1 || out_h2 !== 1'b0 || out_l2 !== 1'b1) begin
                errors++;
                $display("FAIL duty0 j=%0d: h0=%b l0=%b h2=%b l2=%b required h=0 l=1", j, out_h0, out_l0, out_h2, out_l2);
            end
        end
        cfg_write(4'd9, 4'd10, 4'd10);
        wait_wrap(20);
        wait_wrap(20);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (out_h0 !== 1'b1 || out_l0 !== 1'b0 || out_h2 !== 1'b1 || out_l2 !== 1'b0) begin
                errors++;
                $display("FAIL duty_full j=%0d: h0=%b l0=%b h2=%b l2=%b required h=1 l=0", j, out_h0, out_l0, out_h2, out_l2);
            end
        end
    endtask

    task automatic test_reset_in_high();
        checks++;
        if (out_h0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high: got %b required 1", out_h0);
        end
        cfg_write(4'd9, 4'd3, 4'd5);
        checks++;
        if (if0.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_pending: ready=%b required 0", if0.cfg_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_h0 !== 1'b0 || out_l0 !== 1'b0 || out_h2 !== 1'b0 || out_l2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_high_outputs: h0=%b l0=%b h2=%b l2=%b required all 0", out_h0, out_l0, out_h2, out_l2);
        end
        checks++;
        if (cnt_max0 !== 4'd15 || if0.cfg_ready !== 1'b1 || wrap0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_high_state: cnt_max=%0d ready=%b wrap=%b required 15, 1, 0", cnt_max0, if0.cfg_ready, wrap0);
        end
        wait_wrap(40);
        checks++;
        if (cnt_max0 !== 4'd15 || cnt_max2 !== 4'd15) begin
            errors++;
            $display("FAIL pending_cleared: cnt_max=%0d/%0d required 15", cnt_max0, cnt_max2);
        end
        checks++;
        if (out_l0 !== 1'b1 || out_l2 !== 1'b1 || out_h0 !== 1'b0 || out_h2 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_low: h0=%b l0=%b h2=%b l2=%b required h=0 l=1", out_h0, out_l0, out_h2, out_l2);
        end
    endtask

    task automatic test_run_toggle();
        cfg_write(4'd9, 4'd10, 4'd10);
        wait_wrap(40);
        wait_wrap(20);
        checks++;
        if (out_h2 !== 1'b1 || out_h0 !== 1'b1) begin
            errors++;
            $display("FAIL run_pre_high: h0=%b h2=%b required 1", out_h0, out_h2);
        end
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (out_h0 !== 1'b0 || out_l0 !== 1'b0 || out_h2 !== 1'b0 || out_l2 !== 1'b0) begin
            errors++;
            $display("FAIL run_off: h0=%b l0=%b h2=%b l2=%b required all 0", out_h0, out_l0, out_h2, out_l2);
        end
        repeat (2) @(negedge clk);
        run = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (out_h2 !== (j == 3) || out_l2 !== 1'b0) begin
                errors++;
                $display("FAIL run_on_dead2 j=%0d: h=%b l=%b required h=%b l=0", j, out_h2, out_l2, (j == 3));
            end
            checks++;
            if (out_h0 !== 1'b1 || out_l0 !== 1'b0) begin
                errors++;
                $display("FAIL run_on_dead0 j=%0d: h=%b l=%b required h=1 l=0", j, out_h0, out_l0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_shadow_update();
        test_duty_limits();
        test_reset_in_high();
        test_run_toggle();
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL overlap: both outputs high in %0d cycles required 0", overlap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
